// File: rtl/ram_arbiter_2port.sv
// Two-port arbiter in front of a single byte-writable synchronous RAM; one access in flight.
// Define RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module ram_arbiter_2port #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_b,

    input  logic              req0,
    input  logic              rnw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [3:0]        be0_b,
    output logic              ack0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              rnw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [3:0]        be1_b,
    output logic              ack1,
    output logic              rvalid1,

    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rnw,
    output logic [3:0]        ram_cs_b,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_t;

    state_t            state;
    logic              last_grant;
    logic              any_req;
    logic              win;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_be_b;

    assign rdata = ram_dout;
    assign busy  = (state != StIdle);

    always_comb begin
        any_req = req0 | req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        win = ~req0;
`else
        // On contention the port that did not win last time is served.
        if (req0 && req1) begin
            win = ~last_grant;
        end else begin
            win = req1;
        end
`endif
        sel_rnw   = win ? rnw1   : rnw0;
        sel_addr  = win ? addr1  : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_be_b  = win ? be1_b  : be0_b;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= StIdle;
            last_grant  <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            ram_address <= '0;
            ram_din     <= '0;
            ram_rnw     <= 1'b1;
            ram_cs_b    <= 4'hF;
        end else begin
            case (state)
                StIdle: begin
                    if (any_req) begin
                        state       <= StAccess;
                        ram_address <= sel_addr;
                        ram_din     <= sel_wdata;
                        ram_rnw     <= sel_rnw;
                        ram_cs_b    <= sel_rnw ? 4'h0 : sel_be_b;
                        ack0        <= ~win;
                        ack1        <= win;
                        last_grant  <= win;
                    end
                end
                StAccess: begin
                    // ram_rnw and ack still describe the command being issued this cycle.
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    ram_cs_b <= 4'hF;
                    ram_rnw  <= 1'b1;
                    if (ram_rnw) begin
                        state   <= StRdata;
                        rvalid0 <= ack0;
                        rvalid1 <= ack1;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRdata: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Self-checking bench for ram_arbiter_2port with a behavioural byte-writable RAM model.
// Expectations follow RAM_ARB_FIXED_PRIO_EN when it is defined.
module tb_ram_arbiter_2port;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        req0 = 1'b0, rnw0 = 1'b1, req1 = 1'b0, rnw1 = 1'b1;
    logic [12:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  be0_b = 4'hF, be1_b = 4'hF;
    logic        ack0, ack1, rvalid0, rvalid1, busy, ram_rnw;
    logic [31:0] rdata, ram_din;
    logic [31:0] ram_dout = '0;
    logic [12:0] ram_address;
    logic [3:0]  ram_cs_b;

    logic [31:0] mem [0:8191];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    ram_arbiter_2port dut (
        .clk(clk), .reset_b(reset_b),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0), .be0_b(be0_b),
        .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1), .be1_b(be1_b),
        .ack1(ack1), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_din(ram_din), .ram_rnw(ram_rnw),
        .ram_cs_b(ram_cs_b), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered read, per-byte active-low selects.
    always @(posedge clk) begin
        if (ram_cs_b != 4'hF) begin
            if (ram_rnw) begin
                ram_dout <= mem[ram_address];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!ram_cs_b[b]) mem[ram_address][8*b +: 8] = ram_din[8*b +: 8];
                end
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    typedef struct {
        logic        port;
        logic        rnw;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be_b;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic rnw,
                         input logic [12:0] addr, input logic [31:0] wd, input logic [3:0] be);
        if (port) begin
            req1 = req; rnw1 = rnw; addr1 = addr; wdata1 = wd; be1_b = be;
        end else begin
            req0 = req; rnw0 = rnw; addr0 = addr; wdata0 = wd; be0_b = be;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input vec_t v);
        drive(v.port, 1'b1, v.rnw, v.addr, v.wdata, v.be_b);
        @(negedge clk);
        chk1("ack", v.port ? ack1 : ack0, 1'b1);
        chk1("ack_other", v.port ? ack0 : ack1, 1'b0);
        chk32("ram_address", 32'(ram_address), 32'(v.addr));
        chk1("ram_rnw", ram_rnw, v.rnw);
        chk32("ram_cs_b", 32'(ram_cs_b), v.rnw ? 32'h0 : 32'(v.be_b));
        if (!v.rnw) chk32("ram_din", ram_din, v.wdata);
        drive(v.port, 1'b0, 1'b1, '0, '0, 4'hF);
        @(negedge clk);
        if (v.rnw) begin
            chk1("rvalid", v.port ? rvalid1 : rvalid0, 1'b1);
            chk1("rvalid_other", v.port ? rvalid0 : rvalid1, 1'b0);
            chk32("rdata", rdata, v.exp_rdata);
            @(negedge clk);
        end
        chk1("idle_after", busy, 1'b0);
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic g [3];
        logic exp_g [3];
        int   ng, rv0, rv1, wr0;

        for (int i = 0; i < 8192; i++) mem[i] = '0;

        vecs[0] = '{1'b0, 1'b0, 13'h0005, 32'hDEADBEEF, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 13'h0005, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 13'h0005, 32'h11223344, 4'hE, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 13'h0005, 32'h0,        4'hF, 32'hDEADBE44};
        vecs[4] = '{1'b0, 1'b0, 13'h1FFF, 32'hCAFEF00D, 4'hF, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 13'h1FFF, 32'h0,        4'hF, 32'h00000000};
        vecs[6] = '{1'b0, 1'b0, 13'h0A00, 32'hA5A5A5A5, 4'h5, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 13'h0A00, 32'h0,        4'hF, 32'hA500A500};
        vecs[8] = '{1'b1, 1'b0, 13'h0000, 32'h12345678, 4'h0, 32'h0};
        vecs[9] = '{1'b0, 1'b1, 13'h0000, 32'h0,        4'hF, 32'h12345678};

        // Reset state
        @(negedge clk);
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_cs_b", 32'(ram_cs_b), 32'hF);
        chk1("rst_rnw", ram_rnw, 1'b1);
        chk32("rst_address", 32'(ram_address), 32'h0);
        chk32("rst_din", ram_din, 32'h0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) txn(vecs[i]);

        // Contention from reset
        do_reset();
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0};
`endif
        drive(1'b0, 1'b1, 1'b0, 13'h0100, 32'h01000100, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 13'h0101, 32'h01010101, 4'h0);
        ng = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1("ack_exclusive", ack0 & ack1, 1'b0);
            if (ack0 || ack1) begin
                if (ng < 3) g[ng] = ack1;
                ng++;
            end
        end
        chk32("grant_count", 32'(ng), 32'd3);
        for (int k = 0; k < 3; k++) chk1("grant_order", g[k], exp_g[k]);
        req0 = 1'b0;
        @(negedge clk);
        chk1("ack1_after_drop", ack1, 1'b1);
        chk1("ack0_after_drop", ack0, 1'b0);
        req1 = 1'b0;
        @(negedge clk);
        chk1("idle_after_contention", busy, 1'b0);

        // Back-to-back port 0 writes with a fresh command after each ack
        wr0 = wr_cnt;
        drive(1'b0, 1'b1, 1'b0, 13'h0200, 32'h0B0B0000, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("b2b_ack", ack0, 1'b1);
            if (i < 3) drive(1'b0, 1'b1, 1'b0, 13'(13'h0200 + i + 1), 32'h0B0B0000 + 32'(i + 1), 4'h0);
            else       drive(1'b0, 1'b0, 1'b1, '0, '0, 4'hF);
            @(negedge clk);
            chk1("b2b_gap", ack0, 1'b0);
        end
        chk32("b2b_write_count", 32'(wr_cnt - wr0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            v = '{1'b0, 1'b1, 13'(13'h0200 + i), 32'h0, 4'hF, 32'h0B0B0000 + 32'(i)};
            txn(v);
        end

        // Port 1 read against continuous port 0 writes (last grant was port 0)
        drive(1'b0, 1'b1, 1'b0, 13'h0300, 32'h33333333, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 13'h0005, 32'h0, 4'hF);
        rv0 = 0;
        rv1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk1("ack_exclusive_c", ack0 & ack1, 1'b0);
            if (ack1) req1 = 1'b0;
            if (rvalid0) rv0++;
            if (rvalid1) begin
                rv1++;
                chk32("p1_rdata", rdata, 32'hDEADBE44);
            end
        end
        chk32("rvalid0_count", 32'(rv0), 32'd0);
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk32("rvalid1_count", 32'(rv1), 32'd0);
`else
        chk32("rvalid1_count", 32'(rv1), 32'd1);
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk1("idle_after_interleave", busy, 1'b0);

        // Reset during the ACCESS cycle of a write
        wr0 = wr_cnt;
        drive(1'b0, 1'b1, 1'b0, 13'h1FFF, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        chk1("abort_ack_before", ack0, 1'b1);
        chk32("abort_cs_before", 32'(ram_cs_b), 32'h0);
        reset_b = 1'b0;
        #1;
        chk32("abort_cs_b", 32'(ram_cs_b), 32'hF);
        chk1("abort_ack0", ack0, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_rnw", ram_rnw, 1'b1);
        drive(1'b0, 1'b0, 1'b1, '0, '0, 4'hF);
        @(negedge clk);
        chk32("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        reset_b = 1'b1;
        @(negedge clk);
        chk1("abort_no_ack0", ack0, 1'b0);
        chk1("abort_no_rvalid0", rvalid0, 1'b0);
        v = '{1'b1, 1'b1, 13'h1FFF, 32'h0, 4'hF, 32'h00000000};
        txn(v);

        // Reset during RDATA cuts the rvalid pulse
        drive(1'b0, 1'b1, 1'b1, 13'h0005, 32'h0, 4'hF);
        @(negedge clk);
        chk1("cut_ack0", ack0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, '0, '0, 4'hF);
        @(negedge clk);
        chk1("cut_rvalid_before", rvalid0, 1'b1);
        reset_b = 1'b0;
        #1;
        chk1("cut_rvalid_after", rvalid0, 1'b0);
        chk1("cut_busy", busy, 1'b0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
